addsub_accumulator: RTL and testbench
=====================================

# addsub_accumulator

Upstream stage of the add/subtract demo. It holds a 16-bit running value and updates it once per debounced push-button press: add operand, subtract operand, or clear. The result drives `display_driver.bin`, which renders it as five decimal digits (0–65535). Arithmetic saturates at both ends and raises sticky flags that a board LED can show.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: input clock frequency.
- `DEBOUNCE_MS`, 10: required stable time for a button. `DEBOUNCE_CYCLES = CLK_HZ/1000*DEBOUNCE_MS`, minimum 1.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `operand`  in  16  switch value. Sampled at command capture.
- `btn_add_n`  in  1  add button, active-low, asynchronous to `clk`.
- `btn_sub_n`  in  1  subtract button, active-low, asynchronous.
- `btn_clr_n`  in  1  clear button, active-low, asynchronous.
- `bin`  out  16  accumulated value. Feeds `display_driver`.
- `overflow`  out  1  last add saturated at 65535.
- `underflow`  out  1  last subtract saturated at 0.
- `busy`  out  1  high in EXEC and WAIT_REL.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer: a counter clears whenever the synced level equals the debounced level.
  - When the levels differ for `DEBOUNCE_CYCLES` consecutive cycles, the debounced level flips.
  - Press pulse: one cycle, on the debounced released→pressed transition.
- FSM states: IDLE, EXEC, WAIT_REL.
  - IDLE: on any press pulse, latch the op and `operand`, then go to EXEC. Simultaneous pulses resolve by priority CLR > SUB > ADD; lower-priority pulses are dropped.
  - EXEC: one cycle. Update `bin` and the flags, then go to WAIT_REL.
  - WAIT_REL: stay until all three debounced levels are released, then go to IDLE. Press pulses in this state are ignored, so exactly one operation happens per press episode.
- Arithmetic uses a 17-bit intermediate:
  - ADD: if `bin+op` > 65535, `bin` = 65535 and `overflow` = 1. Otherwise store the sum and set `overflow` = 0.
  - SUB: if `op` > `bin`, `bin` = 0 and `underflow` = 1. Otherwise store the difference and set `underflow` = 0.
  - Every EXEC clears the flag not named by its op. CLR sets `bin` = 0 and clears both flags.
- Edge cases:
  - Operand 0 is a legal op. `bin` is unchanged and the relevant flag is cleared.
  - Changes on `operand` outside the capture cycle have no effect.

## Timing
- Reset (async assert, synchronous-release use): `bin` = 0, `overflow` = 0, `underflow` = 0, `busy` = 0, FSM in IDLE.
  - Synchronizers and debounced levels reset to released; debounce counters reset to 0.
  - A button held through reset release yields one press after 2 + `DEBOUNCE_CYCLES` cycles.
- Press-to-pulse latency: 2 sync cycles + `DEBOUNCE_CYCLES` of stable input.
- Pulse in cycle N:
  - Capture at edge N, `busy` high from N+1.
  - `bin` and flags updated at edge N+1, visible in N+2.
- WAIT_REL→IDLE takes 1 cycle after all debounced levels are released. The earliest next capture is the cycle after that.
- `rst_n` assertion in any state (including EXEC) forces reset values immediately. A pending op is discarded.
- Outputs are registered only. There are no combinational paths from any input to any output.

## Structure
- Package `addsub_pkg`:
  - `WIDTH` = 16 and `MAX_VAL` = 16'hFFFF.
  - Op enum: OP_NONE, OP_ADD, OP_SUB, OP_CLR.
  - FSM state enum: IDLE, EXEC, WAIT_REL.
- Sub-module `button_conditioner`: synchronizer + debouncer + press pulse, parameterized by `DEBOUNCE_CYCLES`.
  - Outputs: `level` (debounced, active-high pressed) and `press`.
  - Instantiated three times.
- Top level holds the priority encoder, FSM, saturating datapath and flag registers.

## Test plan
All scenarios use `CLK_HZ`=1000 and `DEBOUNCE_MS`=4, giving `DEBOUNCE_CYCLES` = 4.

- Reset with all buttons released → `bin`=0, `overflow`=0, `underflow`=0, `busy`=0.
- Add then subtract:
  - `operand`=1234, press/release add → `bin`=1234.
  - `operand`=234, press/release sub → `bin`=1000, both flags 0.
- Overflow:
  - From `bin`=65000, add 1000 → `bin`=65535, `overflow`=1.
  - Then sub 535 → `bin`=65000, `overflow`=0.
- Underflow and clear:
  - From `bin`=10, sub 20 → `bin`=0, `underflow`=1.
  - Then clr → both flags 0.
- Bounce and hold with `operand`=5:
  - Toggle `btn_add_n` every 2 cycles for 20 cycles, then hold low for 1000 cycles → exactly one add.
  - `bin` increases by 5, and `busy` stays high until release.
- Simultaneous press and mid-operation reset:
  - Add and clr pressed in the same cycle with `bin`=77 → `bin`=0.
  - Separately, `rst_n` low during EXEC → `bin`=0 immediately and FSM in IDLE.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract accumulator.
//   WIDTH    : datapath width of the running value
//   MAX_VAL  : saturation ceiling for additions
//   op_e     : latched command (none/add/sub/clear)
//   state_e  : control FSM state
//   sat_add / sat_sub : saturating arithmetic returning value + flag
package addsub_pkg;

  localparam int unsigned WIDTH = 16;
  localparam logic [WIDTH-1:0] MAX_VAL = 16'hFFFF;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             sat;
  } sat_result_t;

  // A carry out of the 17-bit sum means the true result exceeds MAX_VAL.
  function automatic sat_result_t sat_add(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    sat_result_t      res;
    logic [WIDTH:0]   sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[WIDTH]) begin
      res.value = MAX_VAL;
      res.sat   = 1'b1;
    end else begin
      res.value = sum[WIDTH-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

  function automatic sat_result_t sat_sub(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    sat_result_t res;
    if (b > a) begin
      res.value = '0;
      res.sat   = 1'b1;
    end else begin
      res.value = a - b;
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/addsub_accumulator_button_conditioner.sv
// Conditions one asynchronous active-low push button.
//   clk, rst_n : system clock, async active-low reset
//   btn_n      : raw button, active-low, asynchronous to clk
//   level      : debounced level, active-high pressed (registered)
//   press      : one-cycle pulse on debounced released->pressed (registered)
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            pressed_sync;

  // Synchronizer holds the raw active-low value; resets to released (1).
  assign sync_d       = {sync_q[0], btn_n};
  assign pressed_sync = ~sync_q[1];

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (pressed_sync == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      // Disagreement has persisted DEBOUNCE_CYCLES cycles: accept new level.
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/addsub_accumulator.sv
// Saturating 16-bit add/subtract accumulator driven by three push buttons.
//   clk, rst_n                      : system clock, async active-low reset
//   operand[15:0]                   : switch value, sampled on command capture
//   btn_add_n, btn_sub_n, btn_clr_n : raw active-low buttons (asynchronous)
//   bin[15:0]                       : accumulated value (to display_driver)
//   overflow                        : last add saturated at 65535
//   underflow                       : last subtract saturated at 0
//   busy                            : high while executing or awaiting release
// All outputs come straight from flops.
module addsub_accumulator
  import addsub_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operand,
  input  logic             btn_add_n,
  input  logic             btn_sub_n,
  input  logic             btn_clr_n,
  output logic [WIDTH-1:0] bin,
  output logic             overflow,
  output logic             underflow,
  output logic             busy
);

  localparam int unsigned DebounceRaw     = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DEBOUNCE_CYCLES = (DebounceRaw < 1) ? 1 : DebounceRaw;

  logic add_level, sub_level, clr_level;
  logic add_press, sub_press, clr_press;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_add (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_add_n),
    .level (add_level),
    .press (add_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_sub (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_sub_n),
    .level (sub_level),
    .press (sub_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_clr_n),
    .level (clr_level),
    .press (clr_press)
  );

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  op_e              press_op;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             busy_q, busy_d;
  logic             any_level;
  sat_result_t      add_res, sub_res;

  // Clear wins over subtract, subtract over add; losers are dropped.
  always_comb begin
    press_op = OP_NONE;
    if (clr_press) begin
      press_op = OP_CLR;
    end else if (sub_press) begin
      press_op = OP_SUB;
    end else if (add_press) begin
      press_op = OP_ADD;
    end
  end

  assign any_level = add_level | sub_level | clr_level;
  assign add_res   = sat_add(bin_q, opnd_q);
  assign sub_res   = sat_sub(bin_q, opnd_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    unique case (state_q)
      IDLE: begin
        if (press_op != OP_NONE) begin
          op_d    = press_op;
          opnd_d  = operand;
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            bin_d = add_res.value;
            ovf_d = add_res.sat;
            udf_d = 1'b0;
          end
          OP_SUB: begin
            bin_d = sub_res.value;
            udf_d = sub_res.sat;
            ovf_d = 1'b0;
          end
          OP_CLR: begin
            bin_d = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
          end
          default: ;
        endcase
        op_d    = OP_NONE;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        // Presses here are ignored: one operation per press episode.
        if (!any_level) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      opnd_q  <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      busy_q  <= busy_d;
    end
  end

  assign bin       = bin_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator with DEBOUNCE_CYCLES = 4.
module tb_addsub_accumulator;
  import addsub_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] operand;
  logic        btn_add_n, btn_sub_n, btn_clr_n;
  logic [15:0] bin;
  logic        overflow, underflow, busy;

  int checks = 0;
  int errors = 0;

  addsub_accumulator #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .operand   (operand),
    .btn_add_n (btn_add_n),
    .btn_sub_n (btn_sub_n),
    .btn_clr_n (btn_clr_n),
    .bin       (bin),
    .overflow  (overflow),
    .underflow (underflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the selected buttons low for 'hold' cycles, release, let the FSM settle.
  task automatic press(input logic [2:0] btns, input logic [15:0] val, input int hold);
    @(negedge clk);
    operand   = val;
    btn_add_n = ~btns[0];
    btn_sub_n = ~btns[1];
    btn_clr_n = ~btns[2];
    repeat (hold) @(negedge clk);
    btn_add_n = 1'b1;
    btn_sub_n = 1'b1;
    btn_clr_n = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  localparam logic [2:0] BtnAdd = 3'b001;
  localparam logic [2:0] BtnSub = 3'b010;
  localparam logic [2:0] BtnClr = 3'b100;

  initial begin
    logic seen;
    rst_n     = 1'b0;
    operand   = '0;
    btn_add_n = 1'b1;
    btn_sub_n = 1'b1;
    btn_clr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bin", 32'(bin), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Add then subtract
    press(BtnAdd, 16'd1234, 12);
    chk("add_1234", 32'(bin), 1234);
    press(BtnSub, 16'd234, 12);
    chk("sub_234", 32'(bin), 1000);
    chk("sub_234_ovf", 32'(overflow), 0);
    chk("sub_234_udf", 32'(underflow), 0);
    chk("idle_busy", 32'(busy), 0);

    // Overflow
    press(BtnClr, 16'd0, 12);
    press(BtnAdd, 16'd65000, 12);
    chk("add_65000", 32'(bin), 65000);
    press(BtnAdd, 16'd1000, 12);
    chk("ovf_bin", 32'(bin), 65535);
    chk("ovf_flag", 32'(overflow), 1);
    press(BtnSub, 16'd535, 12);
    chk("ovf_sub_bin", 32'(bin), 65000);
    chk("ovf_sub_ovf", 32'(overflow), 0);
    chk("ovf_sub_udf", 32'(underflow), 0);

    // Underflow, zero operand, clear
    press(BtnClr, 16'd0, 12);
    press(BtnAdd, 16'd10, 12);
    chk("add_10", 32'(bin), 10);
    press(BtnSub, 16'd20, 12);
    chk("udf_bin", 32'(bin), 0);
    chk("udf_flag", 32'(underflow), 1);
    press(BtnSub, 16'd0, 12);
    chk("sub0_bin", 32'(bin), 0);
    chk("sub0_udf", 32'(underflow), 0);
    press(BtnSub, 16'd20, 12);
    chk("udf2_flag", 32'(underflow), 1);
    press(BtnClr, 16'd0, 12);
    chk("clr_bin", 32'(bin), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);

    // Bounce then long hold: exactly one add of 5
    @(negedge clk);
    operand = 16'd5;
    for (int i = 0; i < 10; i++) begin
      btn_add_n = (i % 2 == 1);
      repeat (2) @(negedge clk);
    end
    chk("bounce_no_op", 32'(bin), 0);
    btn_add_n = 1'b0;
    repeat (500) @(negedge clk);
    operand = 16'd999;
    repeat (500) @(negedge clk);
    chk("hold_bin", 32'(bin), 5);
    chk("hold_busy", 32'(busy), 1);
    btn_add_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("hold_rel_bin", 32'(bin), 5);
    chk("hold_rel_busy", 32'(busy), 0);

    // Simultaneous presses
    press(BtnClr, 16'd0, 12);
    press(BtnAdd, 16'd77, 12);
    chk("set_77", 32'(bin), 77);
    press(BtnAdd | BtnClr, 16'd3, 12);
    chk("add_clr_bin", 32'(bin), 0);
    press(BtnAdd, 16'd77, 12);
    press(BtnAdd | BtnSub, 16'd7, 12);
    chk("add_sub_bin", 32'(bin), 70);

    // Reset during EXEC, then button still held through reset release
    @(negedge clk);
    operand   = 16'd50;
    btn_add_n = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk("exec_reached", 32'(seen), 1);
    chk("exec_state", 32'(dut.state_q), 32'(EXEC));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bin", 32'(bin), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("held_thru_rst_bin", 32'(bin), 50);
    btn_add_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("held_thru_rst_final", 32'(bin), 50);
    chk("final_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
